// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family (adder, subtractor).
package serial_arith_pkg;

   localparam int SERIAL_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } serial_state_e;

endpackage

// File: rtl/serial_shift_reg.sv
// W-bit right shift register: parallel load, shift enable, serial-in at the MSB.
// next_o is the value the register takes on a shift, so callers can capture it early.
module serial_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         ser_i,
   output logic         lsb_o,
   output logic [W-1:0] next_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;
   logic [W-1:0] shifted;

   // A one-bit register has no upper slice; the serial input simply replaces it.
   generate
      if (W == 1) begin : g_one
         assign shifted = ser_i;
      end else begin : g_wide
         assign shifted = {ser_i, q_q[W-1:1]};
      end
   endgenerate

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_val_i;
      end else if (en_i) begin
         q_d = shifted;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign lsb_o  = q_q[0];
   assign next_o = shifted;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first two's-complement adder with start/busy/done handshake.
// Handshake: start is sampled only in IDLE; done pulses for one cycle; sum/cout/ovf hold until the next result.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int W  = SERIAL_W,
   parameter int CW = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic [1:0]   state_o
);

   serial_state_e state_q, state_d;
   logic          carry_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          ovf_q;

   logic          load;
   logic          step;
   logic          last_step;
   logic          qa_lsb;
   logic          qb_lsb;
   logic          s_bit;
   logic          c_next;
   logic [W-1:0]  acc_next;
   logic [W-1:0]  qa_next_unused;
   logic [W-1:0]  qb_next_unused;
   logic          acc_lsb_unused;

   assign s_bit  = qa_lsb ^ qb_lsb ^ carry_q;
   assign c_next = (qa_lsb & qb_lsb) | (qa_lsb & carry_q) | (qb_lsb & carry_q);

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      step      = 1'b0;
      last_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt_q == CW'(1)) begin
               last_step = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            carry_q <= 1'b0;
            cnt_q   <= CW'(W);
         end else if (step) begin
            carry_q <= c_next;
            cnt_q   <= cnt_q - CW'(1);
         end
         // Overflow is carry into the MSB (carry_q on this step) versus carry out of it.
         if (last_step) begin
            sum_q  <= acc_next;
            cout_q <= c_next;
            ovf_q  <= carry_q ^ c_next;
         end
      end
   end

   serial_shift_reg #(.W(W)) u_qa (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .load_val_i (a),
      .en_i       (step),
      .ser_i      (1'b0),
      .lsb_o      (qa_lsb),
      .next_o     (qa_next_unused)
   );

   serial_shift_reg #(.W(W)) u_qb (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .load_val_i (b),
      .en_i       (step),
      .ser_i      (1'b0),
      .lsb_o      (qb_lsb),
      .next_o     (qb_next_unused)
   );

   serial_shift_reg #(.W(W)) u_acc (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .load_val_i ('0),
      .en_i       (step),
      .ser_i      (s_bit),
      .lsb_o      (acc_lsb_unused),
      .next_o     (acc_next)
   );

   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign sum     = sum_q;
   assign cout    = cout_q;
   assign ovf     = ovf_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: W=8 and W=1 instances against an arithmetic reference model.
module tb_serial_adder;
   import serial_arith_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start;
   logic [7:0] a, b;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;
   logic [1:0] state;

   logic       start1;
   logic       a1, b1;
   logic       busy1, done1, cout1, ovf1, sum1;
   logic [1:0] state1;

   serial_adder #(.W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .state_o(state)
   );

   serial_adder #(.W(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .state_o(state1)
   );

   // ---------------- scoreboard ----------------
   logic [9:0] exp_q[$];    // {ovf, cout, sum}
   logic [9:0] held;        // result the outputs must hold between done pulses
   int vectors   = 0;
   int miscompares = 0;

   function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] full;
      logic       v;
      full = {1'b0, x} + {1'b0, y};
      v = (x[7] == y[7]) && (full[7] != x[7]);
      return {v, full[8], full[7:0]};
   endfunction

   function automatic logic [2:0] ref_add1(input logic x, input logic y);
      logic [1:0] full;
      logic       v;
      full = {1'b0, x} + {1'b0, y};
      v = (x == y) && (full[0] != x);
      return {v, full[1], full[0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input string name);
      int n;
      logic [9:0] e;
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      exp_q.push_back(ref_add(av, bv));
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      vectors++;
      if ({ovf, cout, sum} !== held) begin
         miscompares++;
         $display("FAIL %s hold_during_run: got %h expected %h", name, {ovf, cout, sum}, held);
      end
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != 8) begin
         miscompares++;
         $display("FAIL %s busy_cycles: got %0d expected 8", name, n);
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s done_pulse: got %b expected 1", name, done);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h0;
      vectors++;
      if ({ovf, cout, sum} !== e) begin
         miscompares++;
         $display("FAIL %s result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                  name, ovf, cout, sum, e[9], e[8], e[7:0]);
      end
      held = e;
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || state !== ST_IDLE || {ovf, cout, sum} !== held) begin
         miscompares++;
         $display("FAIL %s after_done: got done=%b state=%0d res=%h expected done=0 state=0 res=%h",
                  name, done, state, {ovf, cout, sum}, held);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      start = 1'b0; a = 8'hA5; b = 8'h5A;
      start1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      held = '0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0 || state !== ST_IDLE) begin
         miscompares++;
         $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b ovf=%b state=%0d expected all 0",
                  busy, done, sum, cout, ovf, state);
      end
      vectors++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0 || ovf1 !== 1'b0 || state1 !== ST_IDLE) begin
         miscompares++;
         $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b ovf=%b state=%0d expected all 0",
                  busy1, done1, sum1, cout1, ovf1, state1);
      end
   endtask

   task automatic test_directed();
      do_op(8'h35, 8'h0A, "basic_add");
      do_op(8'hFF, 8'h01, "unsigned_wrap");
      do_op(8'h7F, 8'h01, "signed_ovf_pos");
      do_op(8'h80, 8'h80, "signed_ovf_neg");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         do_op(8'($urandom), 8'($urandom), "random");
      end
      do_op(8'h00, 8'h00, "zeros");
      do_op(8'hFF, 8'hFF, "all_ones");
   endtask

   task automatic test_mid_reset();
      int seen_done;
      @(negedge clk);
      start = 1'b1; a = 8'h12; b = 8'h34;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      held = '0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0 || state !== ST_IDLE) begin
         miscompares++;
         $display("FAIL mid_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b state=%0d expected all 0",
                  busy, done, sum, cout, ovf, state);
      end
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen_done++;
      end
      vectors++;
      if (seen_done != 0) begin
         miscompares++;
         $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", seen_done);
      end
      do_op(8'h12, 8'h34, "after_reset");
   endtask

   task automatic test_back_to_back();
      int t;
      int accepts;
      logic [9:0] e;
      logic exp_busy, exp_done;
      t = 10;
      accepts = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         start = 1'b1; a = 8'($urandom); b = 8'($urandom);
         if (t >= 10) begin
            exp_q.push_back(ref_add(a, b));
            t = 0;
            accepts++;
         end
         @(negedge clk);
         t++;
         exp_busy = (t >= 1 && t <= 8);
         exp_done = (t == 9);
         vectors++;
         if (busy !== exp_busy || done !== exp_done) begin
            miscompares++;
            $display("FAIL b2b_handshake cyc=%0d: got busy=%b done=%b expected busy=%b done=%b",
                     cyc, busy, done, exp_busy, exp_done);
         end
         if (exp_done) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h0;
            held = e;
         end
         vectors++;
         if ({ovf, cout, sum} !== held) begin
            miscompares++;
            $display("FAIL b2b_result cyc=%0d: got %h expected %h", cyc, {ovf, cout, sum}, held);
         end
      end
      start = 1'b0;
      vectors++;
      if (accepts != 4 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_accepts: got %0d accepts %0d pending expected 4 and 0", accepts, exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic test_w1();
      logic [2:0] e;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         e = ref_add1(ab[1], ab[0]);
         @(negedge clk);
         start1 = 1'b1; a1 = ab[1]; b1 = ab[0];
         @(negedge clk);
         start1 = 1'b0; a1 = ~ab[1]; b1 = ~ab[0];
         vectors++;
         if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL w1_run a=%b b=%b: got busy=%b done=%b expected busy=1 done=0", ab[1], ab[0], busy1, done1);
         end
         @(negedge clk);
         vectors++;
         if (busy1 !== 1'b0 || done1 !== 1'b1 || {ovf1, cout1, sum1} !== e) begin
            miscompares++;
            $display("FAIL w1_result a=%b b=%b: got busy=%b done=%b ovf=%b cout=%b sum=%b expected done=1 ovf=%b cout=%b sum=%b",
                     ab[1], ab[0], busy1, done1, ovf1, cout1, sum1, e[2], e[1], e[0]);
         end
         @(negedge clk);
         vectors++;
         if (done1 !== 1'b0 || state1 !== ST_IDLE || {ovf1, cout1, sum1} !== e) begin
            miscompares++;
            $display("FAIL w1_hold a=%b b=%b: got done=%b state=%0d res=%b expected done=0 state=0 res=%b",
                     ab[1], ab[0], done1, state1, {ovf1, cout1, sum1}, e);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_mid_reset();
      test_back_to_back();
      test_w1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
